// File: rtl/alu_core.sv
// Single-cycle 20-bit ALU: combinational opcode decode with registered result and flags.
// Opcode is instruction[3:0]; the upper bits are ignored.
module alu_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [13:0] instruction,
  input  logic [19:0] A,
  input  logic [19:0] B,
  output logic [19:0] result,
  output logic        carry_out,
  output logic        zero
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_AND  = 4'h2, OP_OR   = 4'h3,
    OP_XOR  = 4'h4, OP_NOT  = 4'h5, OP_INC  = 4'h6, OP_DEC  = 4'h7,
    OP_PASA = 4'h8, OP_PASB = 4'h9, OP_SHL  = 4'hA, OP_SHR  = 4'hB,
    OP_SAR  = 4'hC, OP_SLT  = 4'hD, OP_SLTU = 4'hE, OP_NEG  = 4'hF
  } op_e;

  op_e         op;
  logic [4:0]  shamt;
  logic [19:0] result_d, result_q;
  logic        carry_d, carry_q;
  logic        zero_d, zero_q;

  logic [20:0] ext_a, ext_b;
  logic [20:0] shl_ext, shr_ext;
  logic signed [20:0] sar_src, sar_ext;

  assign op    = op_e'(instruction[3:0]);
  assign shamt = B[4:0];
  assign ext_a = {1'b0, A};
  assign ext_b = {1'b0, B};

  // A carry/guard bit rides along each shift so the last bit shifted out lands in a fixed slot;
  // large shift amounts then fall out naturally (zero fill, or sign fill for SAR).
  assign shl_ext = ext_a << shamt;
  assign shr_ext = {A, 1'b0} >> shamt;
  assign sar_src = {A, 1'b0};
  assign sar_ext = sar_src >>> shamt;

  always_comb begin
    result_d = 20'h00000;
    carry_d  = 1'b0;
    unique case (op)
      OP_ADD:  {carry_d, result_d} = ext_a + ext_b;
      OP_SUB:  {carry_d, result_d} = ext_a - ext_b;
      OP_AND:  result_d = A & B;
      OP_OR:   result_d = A | B;
      OP_XOR:  result_d = A ^ B;
      OP_NOT:  result_d = ~A;
      OP_INC:  {carry_d, result_d} = ext_a + 21'd1;
      OP_DEC:  {carry_d, result_d} = ext_a - 21'd1;
      OP_PASA: result_d = A;
      OP_PASB: result_d = B;
      OP_SHL:  {carry_d, result_d} = shl_ext;
      OP_SHR:  {result_d, carry_d} = shr_ext;
      OP_SAR:  {result_d, carry_d} = sar_ext;
      OP_SLT:  result_d = {19'd0, $signed(A) < $signed(B)};
      OP_SLTU: result_d = {19'd0, A < B};
      OP_NEG:  {carry_d, result_d} = 21'd0 - ext_a;
      default: begin
        result_d = 20'h00000;
        carry_d  = 1'b0;
      end
    endcase
    zero_d = (result_d == 20'h00000);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q <= 20'h00000;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed scenarios, shift boundaries, reset behaviour
// and randomized operations against an arithmetic reference model.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [13:0] instruction;
  logic [19:0] A, B;
  logic [19:0] result;
  logic        carry_out, zero;

  int n_vec  = 0;
  int n_miss = 0;

  alu_core dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .A           (A),
    .B           (B),
    .result      (result),
    .carry_out   (carry_out),
    .zero        (zero)
  );

  always #5 clk = ~clk;

  // Reference model: {result[19:0], carry, zero} computed with plain integer arithmetic.
  function automatic logic [21:0] model(input logic [13:0] ins, input logic [19:0] a, input logic [19:0] b);
    longint m  = 64'd1 << 20;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= m / 2) ? ua - m : ua;
    longint sb = (ub >= m / 2) ? ub - m : ub;
    int     n  = int'(b[4:0]);
    longint r  = 0;
    bit     c  = 1'b0;
    logic [19:0] rr;
    case (ins[3:0])
      4'h0: begin r = ua + ub; c = (r >= m); end
      4'h1: begin r = ua - ub; c = (ub > ua); end
      4'h2: r = ua & ub;
      4'h3: r = ua | ub;
      4'h4: r = ua ^ ub;
      4'h5: r = m - 1 - ua;
      4'h6: begin r = ua + 1; c = (ua == m - 1); end
      4'h7: begin r = ua - 1; c = (ua == 0); end
      4'h8: r = ua;
      4'h9: r = ub;
      4'hA: begin
        if (n == 0) r = ua;
        else if (n <= 20) begin r = ua * (64'd1 << n); c = ((ua >> (20 - n)) & 1) != 0; end
        else r = 0;
      end
      4'hB: begin
        if (n == 0) r = ua;
        else if (n <= 20) begin r = ua / (64'd1 << n); c = ((ua >> (n - 1)) & 1) != 0; end
        else r = 0;
      end
      4'hC: begin
        if (n == 0) r = ua;
        else if (n < 20) begin r = sa >>> n; c = ((ua >> (n - 1)) & 1) != 0; end
        else begin r = (sa < 0) ? m - 1 : 0; c = (sa < 0); end
      end
      4'hD: r = (sa < sb) ? 1 : 0;
      4'hE: r = (ua < ub) ? 1 : 0;
      default: begin r = m - ua; c = (ua != 0); end
    endcase
    r  = ((r % m) + m) % m;
    rr = r[19:0];
    return {rr, c, (r == 0)};
  endfunction

  task automatic drive(input logic [13:0] ins, input logic [19:0] a, input logic [19:0] b);
    instruction = ins;
    A = a;
    B = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(14'h0000, 20'hFFFFF, 20'h00001);
    drive(14'($urandom), 20'($urandom), 20'($urandom));
    n_vec++;
    if ({result, carry_out, zero} !== 22'h0) begin
      n_miss++;
      $display("FAIL reset: got r=%h c=%b z=%b, want r=00000 c=0 z=0", result, carry_out, zero);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_scenarios();
    logic [13:0] ins [7] = '{14'h013A, 14'h0000, 14'h0001, 14'h000C, 14'h000A, 14'h000D, 14'h000E};
    logic [19:0] av  [7] = '{20'h000AA, 20'hFFFFF, 20'h00002, 20'h80000, 20'h00001, 20'h80000, 20'h80000};
    logic [19:0] bv  [7] = '{20'h00003, 20'h00001, 20'h00005, 20'h00004, 20'd25, 20'h00001, 20'h00001};
    logic [21:0] want[7] = '{{20'h00550, 2'b00}, {20'h00000, 2'b11}, {20'hFFFFD, 2'b10},
                              {20'hF8000, 2'b00}, {20'h00000, 2'b01}, {20'h00001, 2'b00},
                              {20'h00000, 2'b01}};
    for (int i = 0; i < 7; i++) begin
      drive(ins[i], av[i], bv[i]);
      n_vec++;
      if ({result, carry_out, zero} !== want[i]) begin
        n_miss++;
        $display("FAIL scenario_%0d: got r=%h c=%b z=%b, want %h", i, result, carry_out, zero, want[i]);
      end
    end
    drive(14'h3FFD, 20'h80000, 20'h00001);
    n_vec++;
    if ({result, carry_out, zero} !== {20'h00001, 2'b00}) begin
      n_miss++;
      $display("FAIL slt_reserved: got r=%h c=%b z=%b, want r=00001 c=0 z=0", result, carry_out, zero);
    end
  endtask

  task automatic test_shift_bounds();
    logic [21:0] exp;
    logic [19:0] a;
    logic [19:0] b;
    for (int op = 4'hA; op <= 4'hC; op++) begin
      for (int n = 0; n < 32; n++) begin
        a = (n % 2 == 0) ? 20'h80001 : 20'($urandom);
        b = {15'($urandom), 5'(n)};
        exp = model(14'(op), a, b);
        drive(14'(op), a, b);
        n_vec++;
        if ({result, carry_out, zero} !== exp) begin
          n_miss++;
          $display("FAIL shift op=%h n=%0d A=%h: got r=%h c=%b z=%b, want %h", op, n, a, result, carry_out, zero, exp);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [21:0] exp;
    logic [13:0] ins;
    logic [19:0] a;
    logic [19:0] b;
    for (int i = 0; i < 600; i++) begin
      ins = 14'($urandom);
      a   = ($urandom_range(0, 7) == 0) ? 20'hFFFFF : 20'($urandom);
      b   = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 2)) : 20'($urandom);
      if ($urandom_range(0, 5) == 0) b = a;
      exp = model(ins, a, b);
      drive(ins, a, b);
      n_vec++;
      if ({result, carry_out, zero} !== exp) begin
        n_miss++;
        $display("FAIL random op=%h A=%h B=%h: got r=%h c=%b z=%b, want %h", ins[3:0], a, b, result, carry_out, zero, exp);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [21:0] exp;
    drive(14'h0000, 20'h12345, 20'h11111);
    rst_n = 1'b0;
    drive(14'h0006, 20'hFFFFF, 20'h00000);
    n_vec++;
    if ({result, carry_out, zero} !== 22'h0) begin
      n_miss++;
      $display("FAIL mid_reset: got r=%h c=%b z=%b, want r=00000 c=0 z=0", result, carry_out, zero);
    end
    rst_n = 1'b1;
    exp = model(14'h0007, 20'h00000, 20'h0);
    drive(14'h0007, 20'h00000, 20'h0);
    n_vec++;
    if ({result, carry_out, zero} !== exp) begin
      n_miss++;
      $display("FAIL first_after_reset: got r=%h c=%b z=%b, want %h", result, carry_out, zero, exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [21:0] exp;
    logic [19:0] a;
    for (int i = 0; i < 16; i++) begin
      a = 20'($urandom);
      exp = model(14'(i), a, 20'($unsigned(i * 3)));
      drive(14'(i), a, 20'($unsigned(i * 3)));
      n_vec++;
      if ({result, carry_out, zero} !== exp) begin
        n_miss++;
        $display("FAIL back_to_back op=%h A=%h: got r=%h c=%b z=%b, want %h", i, a, result, carry_out, zero, exp);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    instruction = '0;
    A = '0;
    B = '0;
    test_reset();
    test_scenarios();
    test_shift_bounds();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
